// File: rtl/seg_pkg.sv
// Shared 7-segment constants, decoder state encoding and decode payload.
// Used by both the digit encoder and seg_frame_decoder.
package seg_pkg;

    localparam logic [6:0] SEG_GLYPH_0 = 7'h3F;
    localparam logic [6:0] SEG_GLYPH_1 = 7'h06;
    localparam logic [6:0] SEG_GLYPH_2 = 7'h5B;
    localparam logic [6:0] SEG_GLYPH_3 = 7'h4F;
    localparam logic [6:0] SEG_GLYPH_4 = 7'h66;
    localparam logic [6:0] SEG_GLYPH_5 = 7'h6D;
    localparam logic [6:0] SEG_GLYPH_6 = 7'h7D;
    localparam logic [6:0] SEG_GLYPH_7 = 7'h07;
    localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
    localparam logic [6:0] SEG_GLYPH_9 = 7'h6F;
    localparam logic [6:0] SEG_GLYPH_A = 7'h77;
    localparam logic [6:0] SEG_GLYPH_B = 7'h7C;
    localparam logic [6:0] SEG_GLYPH_C = 7'h39;
    localparam logic [6:0] SEG_GLYPH_D = 7'h5E;
    localparam logic [6:0] SEG_GLYPH_E = 7'h79;
    localparam logic [6:0] SEG_GLYPH_F = 7'h71;
    localparam logic [6:0] SEG_BLANK   = 7'h00;

    typedef enum logic [1:0] {
        TRACK,
        SETTLED,
        PRESENT
    } seg_state_t;

    typedef struct packed {
        logic       err;
        logic       blank;
        logic [3:0] data;
    } seg_dec_t;

endpackage

// File: rtl/seg_glyph_lut.sv
// Combinational 7-segment glyph decoder: pattern -> {err, blank, data}.
// Sole owner of the glyph decode table.
module seg_glyph_lut
    import seg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output seg_dec_t   o_dec_c
);

    always_comb begin
        o_dec_c = '0;
        case (i_pattern)
            SEG_GLYPH_0: o_dec_c.data = 4'h0;
            SEG_GLYPH_1: o_dec_c.data = 4'h1;
            SEG_GLYPH_2: o_dec_c.data = 4'h2;
            SEG_GLYPH_3: o_dec_c.data = 4'h3;
            SEG_GLYPH_4: o_dec_c.data = 4'h4;
            SEG_GLYPH_5: o_dec_c.data = 4'h5;
            SEG_GLYPH_6: o_dec_c.data = 4'h6;
            SEG_GLYPH_7: o_dec_c.data = 4'h7;
            SEG_GLYPH_8: o_dec_c.data = 4'h8;
            SEG_GLYPH_9: o_dec_c.data = 4'h9;
            SEG_GLYPH_A: o_dec_c.data = 4'hA;
            SEG_GLYPH_B: o_dec_c.data = 4'hB;
            SEG_GLYPH_C: o_dec_c.data = 4'hC;
            SEG_GLYPH_D: o_dec_c.data = 4'hD;
            SEG_GLYPH_E: o_dec_c.data = 4'hE;
            SEG_GLYPH_F: o_dec_c.data = 4'hF;
            SEG_BLANK:   o_dec_c.blank = 1'b1;
            default:     o_dec_c.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_frame_decoder.sv
// Stability-filtered 7-segment decoder with valid/ready frame output.
// Optional SEGDEC_ERRCNT_EN adds a saturating err_count output.
module seg_frame_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] segments,
    input  logic       dig_ready,
    output logic       dig_valid,
    output logic [3:0] dig_data,
    output logic       dig_blank,
    output logic       dig_err,
    output logic       overrun
`ifdef SEGDEC_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    seg_state_t       r_state;
    seg_state_t       w_state_nxt;
    logic [6:0]       r_sample;
    logic [6:0]       r_last;
    logic [6:0]       w_last_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             w_same;
    logic             w_settle;
    logic             w_settle_new;
    seg_dec_t         w_dec;
    logic             w_valid_nxt;
    logic [3:0]       w_data_nxt;
    logic             w_blank_nxt;
    logic             w_err_nxt;
    logic             w_ovr_nxt;

    seg_glyph_lut u_lut (
        .i_pattern (r_sample),
        .o_dec_c   (w_dec)
    );

    // A run settles once, when the counter is saturated; r_done blocks re-settling
    assign w_same       = (segments == r_sample);
    assign w_settle     = w_same && (r_cnt == CNT_MAX) && !r_done;
    assign w_settle_new = w_settle && (r_sample != r_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= SEG_BLANK;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_sample <= segments;
            if (!w_same) begin
                r_cnt  <= '0;
                r_done <= 1'b0;
            end else begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_settle) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TRACK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = dig_valid;
        w_data_nxt  = dig_data;
        w_blank_nxt = dig_blank;
        w_err_nxt   = dig_err;
        w_ovr_nxt   = overrun;
        w_last_nxt  = r_last;
        case (r_state)
            TRACK: begin
                if (w_settle) begin
                    w_state_nxt = SETTLED;
                end
            end
            SETTLED: begin
                if (r_sample == r_last) begin
                    w_state_nxt = TRACK;
                end else begin
                    w_state_nxt = PRESENT;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_dec.data;
                    w_blank_nxt = w_dec.blank;
                    w_err_nxt   = w_dec.err;
                    w_last_nxt  = r_sample;
                end
            end
            PRESENT: begin
                // Acceptance wins over a same-cycle settle; that frame goes through SETTLED
                if (dig_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = w_settle_new ? SETTLED : TRACK;
                end else if (w_settle_new) begin
                    w_ovr_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = TRACK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_valid <= 1'b0;
            dig_data  <= 4'h0;
            dig_blank <= 1'b0;
            dig_err   <= 1'b0;
            overrun   <= 1'b0;
            r_last    <= SEG_BLANK;
        end else begin
            dig_valid <= w_valid_nxt;
            dig_data  <= w_data_nxt;
            dig_blank <= w_blank_nxt;
            dig_err   <= w_err_nxt;
            overrun   <= w_ovr_nxt;
            r_last    <= w_last_nxt;
        end
    end

`ifdef SEGDEC_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'h00;
        end else if ((r_state == SETTLED) && (w_state_nxt == PRESENT) && w_dec.err
                     && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Self-checking bench for seg_frame_decoder: vector table, directed corner
// sequences and randomized runs against a run-length reference model.
module tb_seg_frame_decoder;

    localparam int unsigned S = 4;

    typedef struct packed {
        logic       blank;
        logic       err;
        logic [3:0] data;
    } frame_t;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] data;
        logic       blank;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] segments;
    logic       dig_ready;
    logic       dig_valid;
    logic [3:0] dig_data;
    logic       dig_blank;
    logic       dig_err;
    logic       overrun;
`ifdef SEGDEC_ERRCNT_EN
    logic [7:0] err_count;
`endif

    always #5 clk = ~clk;

    seg_frame_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .segments  (segments),
        .dig_ready (dig_ready),
        .dig_valid (dig_valid),
        .dig_data  (dig_data),
        .dig_blank (dig_blank),
        .dig_err   (dig_err),
        .overrun   (overrun)
`ifdef SEGDEC_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    frame_t     frm_q[$];
    logic [6:0] gl [16];
    vec_t       vt [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        segments = p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [6:0] p);
        segments = p;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic frame_t ref_decode(input logic [6:0] p);
        frame_t f;
        f = '0;
        if (p == 7'h00) begin
            f.blank = 1'b1;
        end else begin
            f.err = 1'b1;
            for (int i = 0; i < 16; i++) begin
                if (gl[i] == p) begin
                    f.err  = 1'b0;
                    f.data = 4'(i);
                end
            end
        end
        return f;
    endfunction

    function automatic frame_t q_at(input int i);
        return (i < frm_q.size()) ? frm_q[i] : frame_t'(6'h3F);
    endfunction

    // Collect every accepted frame
    always @(negedge clk) begin
        if (!rst && dig_valid && dig_ready) begin
            frm_q.push_back(frame_t'({dig_blank, dig_err, dig_data}));
            chk("blank_err_exclusive", {31'b0, dig_blank & dig_err}, 32'd0);
        end
    end

    initial begin
        int         first_k;
        logic [3:0] first_data;
        frame_t     exp_f[$];
        frame_t     f;
        logic [6:0] p, prev, last;
        int         len, sel;

        gl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        for (int i = 0; i < 16; i++) vt[i] = '{gl[i], 4'(i), 1'b0, 1'b0};
        vt[16] = '{7'h00, 4'h0, 1'b1, 1'b0};
        vt[17] = '{7'h01, 4'h0, 1'b0, 1'b1};

        rst = 1'b1;
        segments = 7'h4F;
        dig_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset state and first-frame latency
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, dig_valid}, 0);
        chk("rst_data", {28'b0, dig_data}, 0);
        chk("rst_blank", {31'b0, dig_blank}, 0);
        chk("rst_err", {31'b0, dig_err}, 0);
        chk("rst_overrun", {31'b0, overrun}, 0);
        rst = 1'b0;
        first_k = 0;
        first_data = 4'hx;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (dig_valid && first_k == 0) begin
                first_k = k;
                first_data = dig_data;
            end
        end
        chk("latency", first_k, S + 2);
        chk("latency_data", {28'b0, first_data}, 3);
        frm_q.delete();

        // Glitch filter
        hold(7'h06, 3);
        hold(7'h5B, 12);
        chk("glitch_count", frm_q.size(), 1);
        f = q_at(0);
        chk("glitch_frame", {26'b0, f}, {26'b0, 2'b00, 4'h2});

        // Vector table sweep
        frm_q.delete();
        for (int i = 0; i < 18; i++) hold(vt[i].seg, S + 4);
        chk("sweep_count", frm_q.size(), 18);
        for (int i = 0; i < 18; i++) begin
            f = q_at(i);
            chk($sformatf("sweep_%0d", i), {26'b0, f},
                {26'b0, vt[i].blank, vt[i].err, vt[i].data});
        end

        // Backpressure and overrun
        frm_q.delete();
        dig_ready = 1'b0;
        hold(7'h7F, 8);
        hold(7'h71, 10);
        chk("bp_valid", {31'b0, dig_valid}, 1);
        chk("bp_data", {28'b0, dig_data}, 8);
        chk("bp_overrun", {31'b0, overrun}, 1);
        dig_ready = 1'b1;
        hold(7'h71, 20);
        chk("bp_count", frm_q.size(), 1);
        f = q_at(0);
        chk("bp_frame", {26'b0, f}, {26'b0, 2'b00, 4'h8});

        // Long steady input yields a single frame
        frm_q.delete();
        hold(7'h3F, 100);
        chk("steady_count", frm_q.size(), 1);
        f = q_at(0);
        chk("steady_frame", {26'b0, f}, 0);
        chk("overrun_sticky", {31'b0, overrun}, 1);

        // Accept and new settle on the same edge
        do_reset(7'h00);
        chk("overrun_cleared", {31'b0, overrun}, 0);
        frm_q.delete();
        dig_ready = 1'b0;
        hold(7'h66, 8);
        hold(7'h6D, S);
        dig_ready = 1'b1;
        hold(7'h6D, 10);
        chk("simul_count", frm_q.size(), 2);
        f = q_at(0);
        chk("simul_first", {26'b0, f}, 4);
        f = q_at(1);
        chk("simul_second", {26'b0, f}, 5);
        chk("simul_overrun", {31'b0, overrun}, 0);

        // Randomized runs against the run-length model
        do_reset(7'h00);
        frm_q.delete();
        prev = 7'h00;
        last = 7'h00;
        for (int r = 0; r < 60; r++) begin
            sel = $urandom_range(0, 3);
            if (sel < 2) p = gl[$urandom_range(0, 15)];
            else if (sel == 2) p = 7'h00;
            else p = 7'($urandom);
            if (p == prev) p = p ^ 7'h40;
            len = (r == 59) ? 12 : $urandom_range(1, 12);
            hold(p, len);
            if (len >= S + 1 && p != last) begin
                exp_f.push_back(ref_decode(p));
                last = p;
            end
            prev = p;
        end
        hold(prev, 10);
        chk("rand_count", frm_q.size(), exp_f.size());
        for (int i = 0; i < exp_f.size(); i++) begin
            f = q_at(i);
            chk($sformatf("rand_%0d", i), {26'b0, f}, {26'b0, exp_f[i]});
        end
        chk("rand_overrun", {31'b0, overrun}, 0);

        // Reset discards a pending frame
        dig_ready = 1'b0;
        hold(7'h07, 8);
        chk("pend_valid", {31'b0, dig_valid}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("pend_rst_valid", {31'b0, dig_valid}, 0);
        rst = 1'b0;
        dig_ready = 1'b1;

`ifdef SEGDEC_ERRCNT_EN
        do_reset(7'h00);
        chk("errcnt_reset", {24'b0, err_count}, 0);
        for (int i = 0; i < 300; i++) begin
            hold((i % 2 == 0) ? 7'h01 : 7'h02, S + 2);
            if (i == 2) chk("errcnt_3", {24'b0, err_count}, 3);
        end
        chk("errcnt_sat", {24'b0, err_count}, 8'hFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
